// File: rtl/parking_pkg.sv
// Shared types and default constants for the parking gate arbiter.
package parking_pkg;

  localparam int unsigned DEF_CAPACITY     = 8;
  localparam int unsigned DEF_OPEN_CYCLES  = 4;
  localparam int unsigned DEF_HOLD_CYCLES  = 10;
  localparam int unsigned DEF_CLOSE_CYCLES = 4;
  localparam int unsigned DEF_DENY_CYCLES  = 6;

  localparam logic [31:0] DEF_AUTH_TAG_A = 32'h1234_5678;
  localparam logic [31:0] DEF_AUTH_TAG_B = 32'hCAFE_0001;

  localparam int unsigned OCC_W   = 4;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned TAG_W   = 32;

  typedef enum logic [STATE_W-1:0] {
    IDLE    = 3'd0,
    OPENING = 3'd1,
    HOLD    = 3'd2,
    CLOSING = 3'd3,
    DENY    = 3'd4
  } state_t;

  typedef enum logic {
    DIR_ENTRY = 1'b0,
    DIR_EXIT  = 1'b1
  } dir_t;

  // Phase timer width: wide enough for the longest of the four phases.
  function automatic int unsigned timer_width(input int unsigned a, input int unsigned b,
                                              input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/parking_phase_timer.sv
// Loadable down-counter shared by all timed gate phases; done_c when it reaches zero.
module parking_phase_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign done_c = (count == '0);

endmodule

// File: rtl/parking_gate_arbiter.sv
// Shared barrier gate controller: entry/exit arbitration, phase sequencing,
// occupancy tracking and status LEDs. Outputs are registered from the state.
module parking_gate_arbiter
  import parking_pkg::*;
#(
  parameter int unsigned CAPACITY     = DEF_CAPACITY,
  parameter int unsigned OPEN_CYCLES  = DEF_OPEN_CYCLES,
  parameter int unsigned HOLD_CYCLES  = DEF_HOLD_CYCLES,
  parameter int unsigned CLOSE_CYCLES = DEF_CLOSE_CYCLES,
  parameter int unsigned DENY_CYCLES  = DEF_DENY_CYCLES,
  parameter logic [31:0] AUTH_TAG_A   = DEF_AUTH_TAG_A,
  parameter logic [31:0] AUTH_TAG_B   = DEF_AUTH_TAG_B
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                entry_req,
  input  logic [TAG_W-1:0]    entry_tag,
  input  logic                exit_req,
  input  logic                gate_passed,
  output logic                gate_open,
  output logic                grant_entry,
  output logic                grant_exit,
  output logic                deny_entry,
  output logic                GREEN_LED,
  output logic                RED_LED,
  output logic [OCC_W-1:0]    occupancy,
  output logic                full,
  output logic [STATE_W-1:0]  state_dbg
);

  localparam int unsigned TIMER_W =
    timer_width(OPEN_CYCLES, HOLD_CYCLES, CLOSE_CYCLES, DENY_CYCLES);

  state_t             state;
  state_t             next_state_c;
  dir_t               dir;
  dir_t               last_served;
  logic               timer_load_c;
  logic [TIMER_W-1:0] timer_val_c;
  logic               timer_done_c;
  logic [OCC_W-1:0]   occ_next_c;
  logic               serve_exit_c;
  logic               serve_entry_c;
  logic               entry_ok_c;
  logic               grant_entry_pend;
  logic               grant_exit_pend;
  logic               deny_pend;

  parking_phase_timer #(.W(TIMER_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (timer_load_c),
    .load_val (timer_val_c),
    .done_c   (timer_done_c)
  );

  // Arbitration: a full lot hands priority to the exit, otherwise round-robin.
  assign serve_exit_c  = (state == IDLE) && exit_req &&
                         (!entry_req || full || (last_served == DIR_ENTRY));
  assign serve_entry_c = (state == IDLE) && entry_req && !serve_exit_c;
  assign entry_ok_c    = ((entry_tag == AUTH_TAG_A) || (entry_tag == AUTH_TAG_B)) && !full;

  // Next state; every state change reloads the phase timer for the new phase.
  always_comb begin
    next_state_c = state;
    timer_load_c = 1'b0;
    timer_val_c  = '0;
    case (state)
      IDLE: begin
        if (serve_exit_c || (serve_entry_c && entry_ok_c)) begin
          next_state_c = OPENING;
          timer_load_c = 1'b1;
          timer_val_c  = TIMER_W'(OPEN_CYCLES - 1);
        end else if (serve_entry_c) begin
          next_state_c = DENY;
          timer_load_c = 1'b1;
          timer_val_c  = TIMER_W'(DENY_CYCLES - 1);
        end
      end
      OPENING: if (timer_done_c) begin
        next_state_c = HOLD;
        timer_load_c = 1'b1;
        timer_val_c  = TIMER_W'(HOLD_CYCLES - 1);
      end
      HOLD: if (gate_passed || timer_done_c) begin
        next_state_c = CLOSING;
        timer_load_c = 1'b1;
        timer_val_c  = TIMER_W'(CLOSE_CYCLES - 1);
      end
      CLOSING: if (timer_done_c) next_state_c = IDLE;
      DENY:    if (timer_done_c) next_state_c = IDLE;
      default: next_state_c = IDLE;
    endcase
  end

  // Saturating count update on a confirmed pass through the gate.
  always_comb begin
    occ_next_c = occupancy;
    if ((state == HOLD) && gate_passed) begin
      if ((dir == DIR_ENTRY) && (occupancy < OCC_W'(CAPACITY))) begin
        occ_next_c = occupancy + OCC_W'(1);
      end else if ((dir == DIR_EXIT) && (occupancy != '0)) begin
        occ_next_c = occupancy - OCC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      dir              <= DIR_EXIT;
      last_served      <= DIR_EXIT;
      occupancy        <= '0;
      full             <= 1'b0;
      grant_entry_pend <= 1'b0;
      grant_exit_pend  <= 1'b0;
      deny_pend        <= 1'b0;
      grant_entry      <= 1'b0;
      grant_exit       <= 1'b0;
      deny_entry       <= 1'b0;
      gate_open        <= 1'b0;
      GREEN_LED        <= 1'b0;
      RED_LED          <= 1'b0;
    end else begin
      state     <= next_state_c;
      occupancy <= occ_next_c;
      full      <= (occ_next_c == OCC_W'(CAPACITY));
      if ((state == IDLE) && (next_state_c != IDLE)) begin
        dir         <= serve_exit_c ? DIR_EXIT : DIR_ENTRY;
        last_served <= serve_exit_c ? DIR_EXIT : DIR_ENTRY;
      end
      // Pulses are staged one cycle so they line up with gate_open.
      grant_entry_pend <= (state == IDLE) && (next_state_c == OPENING) && !serve_exit_c;
      grant_exit_pend  <= (state == IDLE) && (next_state_c == OPENING) && serve_exit_c;
      deny_pend        <= (state == IDLE) && (next_state_c == DENY);
      grant_entry      <= grant_entry_pend;
      grant_exit       <= grant_exit_pend;
      deny_entry       <= deny_pend;
      gate_open        <= (state == OPENING) || (state == HOLD);
      GREEN_LED        <= (state == OPENING) || (state == HOLD);
      RED_LED          <= (state == DENY) || ((state == IDLE) && full);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed self-checking bench for parking_gate_arbiter.
module tb_parking_gate_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        entry_req;
  logic [31:0] entry_tag;
  logic        exit_req;
  logic        gate_passed;
  logic        gate_open;
  logic        grant_entry;
  logic        grant_exit;
  logic        deny_entry;
  logic        GREEN_LED;
  logic        RED_LED;
  logic [3:0]  occupancy;
  logic        full;
  logic [2:0]  state_dbg;

  int unsigned total    = 0;
  int unsigned pass_cnt = 0;
  int unsigned fail_cnt = 0;
  int unsigned open_cnt, green_cnt, grant_cnt, red_cnt, deny_cnt, cls_cnt, hold_cnt;

  always #5 clk = ~clk;

  parking_gate_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .entry_req   (entry_req),
    .entry_tag   (entry_tag),
    .exit_req    (exit_req),
    .gate_passed (gate_passed),
    .gate_open   (gate_open),
    .grant_entry (grant_entry),
    .grant_exit  (grant_exit),
    .deny_entry  (deny_entry),
    .GREEN_LED   (GREEN_LED),
    .RED_LED     (RED_LED),
    .occupancy   (occupancy),
    .full        (full),
    .state_dbg   (state_dbg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_entry_pass();
    entry_req = 1'b1;
    entry_tag = 32'hCAFE0001;
    tick();
    entry_req = 1'b0;
    repeat (6) tick();
    gate_passed = 1'b1;
    tick();
    gate_passed = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    reset_n     = 1'b0;
    entry_req   = 1'b0;
    entry_tag   = 32'h0;
    exit_req    = 1'b0;
    gate_passed = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_state", 32'(state_dbg), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_outs", 32'({gate_open, grant_entry, grant_exit, deny_entry, GREEN_LED, RED_LED, full}), 32'd0);
    reset_n = 1'b1;
    tick();

    // Authorised entry, car passes in HOLD cycle 3
    entry_req = 1'b1;
    entry_tag = 32'h12345678;
    tick();
    check("ent_state_open", 32'(state_dbg), 32'd1);
    check("ent_gate_latency", 32'(gate_open), 32'd0);
    entry_req = 1'b0;
    open_cnt = 0; green_cnt = 0; grant_cnt = 0; cls_cnt = 0;
    for (int i = 2; i <= 14; i++) begin
      tick();
      if (gate_open) open_cnt++;
      if (GREEN_LED) green_cnt++;
      if (grant_entry) grant_cnt++;
      if (state_dbg == 3'd3) cls_cnt++;
      if (i == 2) check("ent_grant_first", 32'({grant_entry, gate_open, GREEN_LED}), 32'h7);
      if (i == 8) check("ent_occ_at_pass", 32'({state_dbg, occupancy}), 32'h31);
      gate_passed = (i == 7);
    end
    check("ent_open_cycles", 32'(open_cnt), 32'd7);
    check("ent_green_cycles", 32'(green_cnt), 32'd7);
    check("ent_grant_pulses", 32'(grant_cnt), 32'd1);
    check("ent_close_cycles", 32'(cls_cnt), 32'd4);
    check("ent_end", 32'({state_dbg, occupancy}), 32'h01);

    // Unauthorised tag is denied
    entry_req = 1'b1;
    entry_tag = 32'h87654321;
    tick();
    check("deny_state", 32'(state_dbg), 32'd4);
    entry_req = 1'b0;
    red_cnt = 0; deny_cnt = 0; open_cnt = 0;
    for (int i = 2; i <= 10; i++) begin
      tick();
      if (RED_LED) red_cnt++;
      if (deny_entry) deny_cnt++;
      if (gate_open) open_cnt++;
      if (i == 2) check("deny_first", 32'({deny_entry, RED_LED}), 32'h3);
    end
    check("deny_red_cycles", 32'(red_cnt), 32'd6);
    check("deny_pulses", 32'(deny_cnt), 32'd1);
    check("deny_gate_closed", 32'(open_cnt), 32'd0);
    check("deny_end", 32'({state_dbg, occupancy}), 32'h01);

    // Granted entry with no pass: HOLD times out
    entry_req = 1'b1;
    entry_tag = 32'hCAFE0001;
    tick();
    entry_req = 1'b0;
    open_cnt = 0; hold_cnt = 0;
    for (int i = 2; i <= 21; i++) begin
      tick();
      if (gate_open) open_cnt++;
      if (state_dbg == 3'd2) hold_cnt++;
    end
    check("tmo_hold_cycles", 32'(hold_cnt), 32'd10);
    check("tmo_open_cycles", 32'(open_cnt), 32'd14);
    check("tmo_end", 32'({state_dbg, occupancy}), 32'h01);

    // Reach 3 cars, then reset in the middle of HOLD
    do_entry_pass();
    do_entry_pass();
    entry_req = 1'b1;
    tick();
    entry_req = 1'b0;
    repeat (6) tick();
    check("mid_hold", 32'({state_dbg, occupancy}), 32'h23);
    reset_n = 1'b0;
    tick();
    tick();
    check("mid_rst_state", 32'({state_dbg, occupancy}), 32'h00);
    check("mid_rst_outs", 32'({gate_open, grant_entry, grant_exit, deny_entry, GREEN_LED, RED_LED, full}), 32'd0);
    reset_n = 1'b1;
    tick();

    // Exit at zero occupancy; pass during CLOSING is ignored
    exit_req = 1'b1;
    tick();
    exit_req = 1'b0;
    tick();
    check("ex0_grant", 32'({grant_exit, grant_entry, gate_open}), 32'h5);
    repeat (5) tick();
    gate_passed = 1'b1;
    tick();
    gate_passed = 1'b0;
    check("ex0_after_pass", 32'({state_dbg, occupancy}), 32'h30);
    tick();
    gate_passed = 1'b1;
    tick();
    gate_passed = 1'b0;
    repeat (3) tick();
    check("ex0_end", 32'({state_dbg, occupancy}), 32'h00);

    // Fill the lot
    for (int n = 0; n < 8; n++) do_entry_pass();
    check("fill_occ", 32'({full, occupancy}), 32'h18);
    tick();
    check("fill_red_idle", 32'(RED_LED), 32'd1);

    // Valid tag while full is still denied
    entry_req = 1'b1;
    entry_tag = 32'h12345678;
    tick();
    check("full_deny_state", 32'(state_dbg), 32'd4);
    entry_req = 1'b0;
    tick();
    check("full_deny_pulse", 32'({deny_entry, grant_entry}), 32'h2);
    repeat (6) tick();
    check("full_deny_end", 32'({state_dbg, occupancy}), 32'h08);

    // Both lanes while full: exit first, then entry
    entry_req = 1'b1;
    exit_req  = 1'b1;
    tick();
    exit_req = 1'b0;
    tick();
    check("both_exit_first", 32'({grant_exit, grant_entry}), 32'h2);
    repeat (5) tick();
    gate_passed = 1'b1;
    tick();
    gate_passed = 1'b0;
    check("both_occ7", 32'({full, occupancy}), 32'h07);
    repeat (4) tick();
    check("both_idle", 32'(state_dbg), 32'd0);
    tick();
    check("both_entry_open", 32'(state_dbg), 32'd1);
    entry_req = 1'b0;
    tick();
    check("both_entry_grant", 32'({grant_entry, grant_exit}), 32'h2);
    repeat (5) tick();
    gate_passed = 1'b1;
    tick();
    gate_passed = 1'b0;
    check("both_occ8", 32'({full, occupancy}), 32'h18);
    repeat (4) tick();
    check("both_end", 32'(state_dbg), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
